pcs_link_bringup_fsm: RTL and testbench
=======================================

Name: pcs_link_bringup_fsm

Overview:
Sequences bring-up of the PCS loopback datapath by driving the register-file enable and reset controls in order. Each receive stage is enabled only after the previous stage reports lock, with per-stage timeout and bounded retry. It sits between rf_write, which provides start/abort and limits, and the PCS enable inputs. It replaces manual software enable poking.

Parameters:
N_LANES, 20, number of PCS lanes
NB_TIMEOUT, 24, width of the stage timeout counter and limit
NB_RETRY, 4, width of the retry limit and retry counter
RESET_CYCLES, 16, cycles o_pcs_reset is held in RESET state (>=1)

Ports:
i_clock  in  1  PCS clock; single clock domain
i_reset  in  1  synchronous, active-high reset
i_start  in  1  level sampled each cycle; starts bring-up from IDLE or FAIL
i_abort  in  1  forces IDLE
i_rf_timeout_limit  in  NB_TIMEOUT  max cycles per wait state; 0 = no timeout
i_rf_max_retries  in  NB_RETRY  retries allowed before FAIL
i_lanes_block_lock  in  N_LANES  block-sync lock per lane
i_am_lock  in  N_LANES  aligner AM lock per lane
i_deskew_done  in  1  deskewer done
o_pcs_reset  out  1  PCS datapath reset
o_enb_tx  out  1  enables TX frame gen/encoder/scrambler/pc/am insertion
o_enb_block_sync  out  1  RX block sync enable
o_enb_aligner  out  1  RX aligner enable
o_enb_deskewer  out  1  RX deskewer enable
o_enb_rx_tail  out  1  enables reorder, descrambler, pattern checker, decoder
o_reset_order  out  1  1-cycle lane-reorder reset pulse
o_state  out  3  current state encoding
o_link_up  out  1  link fully up
o_fail  out  1  bring-up failed
o_retry_count  out  NB_RETRY  retries consumed in the current attempt

Behaviour:
- States and encoding: IDLE=0, RESET=1, WAIT_BLK=2, WAIT_AM=3, WAIT_DESKEW=4, ENABLE_RX=5, LINK_UP=6, FAIL=7.
- Moore outputs: every output is decoded from registered state and counters only; no input-to-output combinational path.
- Latency: a condition sampled at edge k is visible on outputs after edge k.
- i_reset (sync): state=IDLE, timer=0, retry_count=0. Outputs take IDLE values: o_pcs_reset=1, all enables 0, o_reset_order=0, o_link_up=0, o_fail=0.
- Output decode per state:
  - IDLE, FAIL: pcs_reset=1, all enables 0. o_fail=1 only in FAIL.
  - RESET: pcs_reset=1, all enables 0.
  - WAIT_BLK: tx, block_sync.
  - WAIT_AM: adds aligner.
  - WAIT_DESKEW: adds deskewer.
  - ENABLE_RX: adds rx_tail; o_reset_order=1. Lasts exactly 1 cycle.
  - LINK_UP: all enables 1, o_link_up=1.
- Timer: cleared on every state entry, increments each cycle in RESET and wait states, saturates at all-ones.
- Transitions:
  - IDLE: i_start -> RESET.
  - RESET: timer==RESET_CYCLES-1 -> WAIT_BLK.
  - WAIT_BLK: &i_lanes_block_lock -> WAIT_AM.
  - WAIT_AM: &i_am_lock, with block lock still all-1 -> WAIT_DESKEW.
  - WAIT_DESKEW: i_deskew_done -> ENABLE_RX.
  - ENABLE_RX: unconditional -> LINK_UP.
  - LINK_UP: any block-lock or am-lock bit 0, or deskew_done 0 -> RESET with retry_count cleared (link loss is not a retry).
  - FAIL: i_start -> RESET; retry_count cleared; o_fail drops on the same edge.
- Timeout (wait states only): limit!=0 and timer==limit-1 and advance condition false.
  - If retry_count < i_rf_max_retries: retry_count++ and go to RESET.
  - Otherwise go to FAIL; retry_count holds its value.
- In WAIT_AM or WAIT_DESKEW, loss of a lower-stage lock is handled as a timeout-class retry immediately, without waiting for the timer.
- Priority: i_reset > i_abort > advance condition > timeout.
  - i_abort in any state -> IDLE with retry_count cleared.
  - Lock and timeout on the same cycle: advance wins.
- i_start is ignored outside IDLE and FAIL.
- Limit inputs are sampled live, not latched.
- i_rf_max_retries=0 means the first timeout goes straight to FAIL.

Test Plan:
1. Nominal: limit=1000, RESET_CYCLES=16, i_start pulse. Block lock all-1 50 cycles after RESET exit, am_lock 100 cycles later, deskew 20 cycles later -> o_state 1,2,3,4,5,6; RESET lasts 16 cycles; exactly one 1-cycle o_reset_order; o_link_up=1; retry=0.
2. Partial lock: 19/20 lanes locked, limit=100, max_retries=2 -> three 100-cycle WAIT_BLK attempts, retry 0→1→2, then FAIL (o_fail=1, pcs_reset=1). i_start -> RESET, retry=0, o_fail=0.
3. Link loss: in LINK_UP, drop i_am_lock[7] for 1 cycle -> RESET next cycle, o_link_up=0, all enables 0, retry=0, then re-lock to LINK_UP.
4. Abort in WAIT_AM -> IDLE next cycle, enables 0, pcs_reset=1. i_start re-runs the full sequence.
5. Boundary: deskew_done rises on the exact timeout cycle -> ENABLE_RX, no retry. limit=0 with no lock for 10000 cycles -> stays in WAIT_BLK, no timeout.
6. i_reset asserted 1 cycle in WAIT_DESKEW with retry=1 -> all outputs at reset values next edge, retry=0, state=IDLE.

Source files
------------

// File: rtl/pcs_link_bringup_fsm.sv
// pcs_link_bringup_fsm
// Brings the PCS loopback datapath up one receive stage at a time.
// A stage is enabled only after the stage below it reports lock.
// Each wait state has its own timeout, and retries are bounded.
// Every output is decoded from registered state only (Moore).
//
// Control semantics: i_start and i_abort are levels sampled every cycle.
// There is no valid/ready handshake. i_start only counts in IDLE or FAIL.
// i_abort wins over everything except i_reset.
module pcs_link_bringup_fsm #(
  parameter int N_LANES      = 20,
  parameter int NB_TIMEOUT   = 24,
  parameter int NB_RETRY     = 4,
  parameter int RESET_CYCLES = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [NB_TIMEOUT-1:0] i_rf_timeout_limit,
  input  logic [NB_RETRY-1:0]   i_rf_max_retries,
  input  logic [N_LANES-1:0]    i_lanes_block_lock,
  input  logic [N_LANES-1:0]    i_am_lock,
  input  logic                  i_deskew_done,
  output logic                  o_pcs_reset,
  output logic                  o_enb_tx,
  output logic                  o_enb_block_sync,
  output logic                  o_enb_aligner,
  output logic                  o_enb_deskewer,
  output logic                  o_enb_rx_tail,
  output logic                  o_reset_order,
  output logic [2:0]            o_state,
  output logic                  o_link_up,
  output logic                  o_fail,
  output logic [NB_RETRY-1:0]   o_retry_count
);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_RESET       = 3'd1;
  localparam logic [2:0] ST_WAIT_BLK    = 3'd2;
  localparam logic [2:0] ST_WAIT_AM     = 3'd3;
  localparam logic [2:0] ST_WAIT_DESKEW = 3'd4;
  localparam logic [2:0] ST_ENABLE_RX   = 3'd5;
  localparam logic [2:0] ST_LINK_UP     = 3'd6;
  localparam logic [2:0] ST_FAIL        = 3'd7;

  localparam logic [NB_TIMEOUT-1:0] RESET_LAST = NB_TIMEOUT'(RESET_CYCLES - 1);

  logic [2:0]            state, state_nxt;
  logic [NB_TIMEOUT-1:0] timer, timer_nxt;
  logic [NB_RETRY-1:0]   retry_count, retry_nxt;

  logic all_blk;
  logic all_am;
  logic timeout_hit;
  logic retry_take;
  logic counting;

  assign all_blk = &i_lanes_block_lock;
  assign all_am  = &i_am_lock;

  // A limit of zero disables the timeout.
  // A non-zero limit L fires on the L-th cycle spent in a wait state.
  assign timeout_hit = (i_rf_timeout_limit != '0) &&
                       (timer == (i_rf_timeout_limit - NB_TIMEOUT'(1)));

  // The timer only runs in RESET and in the wait states.
  assign counting = (state == ST_RESET) || (state == ST_WAIT_BLK) ||
                    (state == ST_WAIT_AM) || (state == ST_WAIT_DESKEW);

  // Next-state, retry and timer logic.
  // Advance beats timeout, and a failed stage becomes a retry or FAIL.
  always_comb begin
    state_nxt  = state;
    retry_nxt  = retry_count;
    retry_take = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = ST_RESET;
      end
      ST_RESET: begin
        if (timer == RESET_LAST) state_nxt = ST_WAIT_BLK;
      end
      ST_WAIT_BLK: begin
        if (all_blk)          state_nxt  = ST_WAIT_AM;
        else if (timeout_hit) retry_take = 1'b1;
      end
      ST_WAIT_AM: begin
        // Losing block lock here is a retry at once; there is no timer wait.
        if (all_am && all_blk)          state_nxt  = ST_WAIT_DESKEW;
        else if (!all_blk || timeout_hit) retry_take = 1'b1;
      end
      ST_WAIT_DESKEW: begin
        if (i_deskew_done)                          state_nxt  = ST_ENABLE_RX;
        else if (!all_blk || !all_am || timeout_hit) retry_take = 1'b1;
      end
      ST_ENABLE_RX: begin
        state_nxt = ST_LINK_UP;
      end
      ST_LINK_UP: begin
        // Losing the link restarts bring-up with a fresh retry budget.
        if (!(all_blk && all_am && i_deskew_done)) begin
          state_nxt = ST_RESET;
          retry_nxt = '0;
        end
      end
      ST_FAIL: begin
        if (i_start) begin
          state_nxt = ST_RESET;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        retry_nxt = '0;
      end
    endcase

    if (retry_take) begin
      if (retry_count < i_rf_max_retries) begin
        state_nxt = ST_RESET;
        retry_nxt = retry_count + NB_RETRY'(1);
      end else begin
        state_nxt = ST_FAIL;
      end
    end

    if (i_abort) begin
      state_nxt = ST_IDLE;
      retry_nxt = '0;
    end

    // The timer clears on every state entry and saturates at all-ones.
    if (state_nxt != state)                timer_nxt = '0;
    else if (counting && (timer != '1))    timer_nxt = timer + NB_TIMEOUT'(1);
    else                                   timer_nxt = timer;
  end

  // State, timer and retry registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      retry_count <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      retry_count <= retry_nxt;
    end
  end

  // Moore output decode from registered state.
  always_comb begin
    o_pcs_reset      = 1'b0;
    o_enb_tx         = 1'b0;
    o_enb_block_sync = 1'b0;
    o_enb_aligner    = 1'b0;
    o_enb_deskewer   = 1'b0;
    o_enb_rx_tail    = 1'b0;
    o_reset_order    = 1'b0;
    o_link_up        = 1'b0;
    o_fail           = 1'b0;
    case (state)
      ST_WAIT_BLK: begin
        o_enb_tx         = 1'b1;
        o_enb_block_sync = 1'b1;
      end
      ST_WAIT_AM: begin
        o_enb_tx         = 1'b1;
        o_enb_block_sync = 1'b1;
        o_enb_aligner    = 1'b1;
      end
      ST_WAIT_DESKEW: begin
        o_enb_tx         = 1'b1;
        o_enb_block_sync = 1'b1;
        o_enb_aligner    = 1'b1;
        o_enb_deskewer   = 1'b1;
      end
      ST_ENABLE_RX: begin
        o_enb_tx         = 1'b1;
        o_enb_block_sync = 1'b1;
        o_enb_aligner    = 1'b1;
        o_enb_deskewer   = 1'b1;
        o_enb_rx_tail    = 1'b1;
        o_reset_order    = 1'b1;
      end
      ST_LINK_UP: begin
        o_enb_tx         = 1'b1;
        o_enb_block_sync = 1'b1;
        o_enb_aligner    = 1'b1;
        o_enb_deskewer   = 1'b1;
        o_enb_rx_tail    = 1'b1;
        o_link_up        = 1'b1;
      end
      ST_FAIL: begin
        o_pcs_reset = 1'b1;
        o_fail      = 1'b1;
      end
      default: begin
        o_pcs_reset = 1'b1;
      end
    endcase
  end

  assign o_state       = state;
  assign o_retry_count = retry_count;

endmodule

// File: tb/tb_pcs_link_bringup_fsm.sv
// Self-checking bench for pcs_link_bringup_fsm.
// Lock delays and limits are random. Expected states, durations and outputs
// come from the bring-up rules: the output table per state, stage outcome
// by delay versus limit, and retry budgeting.
// An independent monitor records every state change and every
// reset_order pulse, and these are compared with what the steps predicted.
module tb_pcs_link_bringup_fsm;

  localparam int N_LANES      = 20;
  localparam int NB_TIMEOUT   = 24;
  localparam int NB_RETRY     = 4;
  localparam int RESET_CYCLES = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_BLK    = 3'd2;
  localparam logic [2:0] S_AM     = 3'd3;
  localparam logic [2:0] S_DESKEW = 3'd4;
  localparam logic [2:0] S_ENRX   = 3'd5;
  localparam logic [2:0] S_UP     = 3'd6;
  localparam logic [2:0] S_FAIL   = 3'd7;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  abort;
  logic [NB_TIMEOUT-1:0] limit;
  logic [NB_RETRY-1:0]   maxr;
  logic [N_LANES-1:0]    blk;
  logic [N_LANES-1:0]    am;
  logic                  dsk;

  logic                  o_pcs_reset, o_enb_tx, o_enb_block_sync, o_enb_aligner;
  logic                  o_enb_deskewer, o_enb_rx_tail, o_reset_order;
  logic [2:0]            o_state;
  logic                  o_link_up, o_fail;
  logic [NB_RETRY-1:0]   o_retry_count;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ro   = 0;
  int exp_ro = 0;

  // Scoreboard of state changes: expected sequence vs. observed sequence.
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];
  logic [2:0] last_exp = S_IDLE;
  logic [2:0] mon_prev = S_IDLE;
  bit         mon_on   = 1'b0;

  pcs_link_bringup_fsm #(
    .N_LANES(N_LANES), .NB_TIMEOUT(NB_TIMEOUT),
    .NB_RETRY(NB_RETRY), .RESET_CYCLES(RESET_CYCLES)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .i_rf_timeout_limit(limit), .i_rf_max_retries(maxr),
    .i_lanes_block_lock(blk), .i_am_lock(am), .i_deskew_done(dsk),
    .o_pcs_reset(o_pcs_reset), .o_enb_tx(o_enb_tx),
    .o_enb_block_sync(o_enb_block_sync), .o_enb_aligner(o_enb_aligner),
    .o_enb_deskewer(o_enb_deskewer), .o_enb_rx_tail(o_enb_rx_tail),
    .o_reset_order(o_reset_order), .o_state(o_state),
    .o_link_up(o_link_up), .o_fail(o_fail), .o_retry_count(o_retry_count)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Monitor on the falling edge: record state changes and count reset_order pulses.
  always @(negedge clk) begin
    if (mon_on) begin
      if (o_state !== mon_prev) begin
        obs_q.push_back(o_state);
        mon_prev = o_state;
      end
      if (o_reset_order === 1'b1) n_ro++;
    end
  end

  // Output table per state, packed as
  // {pcs_reset, tx, block_sync, aligner, deskewer, rx_tail, reset_order, link_up, fail}.
  function automatic logic [8:0] exp_outs(logic [2:0] s);
    case (s)
      S_BLK:    return 9'b0_11000_000;
      S_AM:     return 9'b0_11100_000;
      S_DESKEW: return 9'b0_11110_000;
      S_ENRX:   return 9'b0_11111_100;
      S_UP:     return 9'b0_11111_010;
      S_FAIL:   return 9'b1_00000_001;
      default:  return 9'b1_00000_000;
    endcase
  endfunction

  // A stage whose condition first shows after d cycles advances if d < limit.
  // Otherwise it times out. A limit of 0 never times out.
  function automatic bit stage_advances(int d, int lim);
    return (lim == 0) || (d < lim);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(string tag, logic [2:0] s, logic [NB_RETRY-1:0] r);
    if (s !== last_exp) begin
      exp_q.push_back(s);
      last_exp = s;
    end
    chk({tag, "_state"}, 32'(o_state), 32'(s));
    chk({tag, "_outs"},
        32'({o_pcs_reset, o_enb_tx, o_enb_block_sync, o_enb_aligner, o_enb_deskewer,
             o_enb_rx_tail, o_reset_order, o_link_up, o_fail}),
        32'(exp_outs(s)));
    chk({tag, "_retry"}, 32'(o_retry_count), 32'(r));
  endtask

  // Run n cycles and require that the state never leaves s.
  task automatic hold(int n, logic [2:0] s, string tag);
    logic [2:0] bad;
    bit ok;
    ok  = 1'b1;
    bad = s;
    for (int i = 0; i < n; i++) begin
      step();
      if (ok && (o_state !== s)) begin
        ok  = 1'b0;
        bad = o_state;
      end
    end
    if (n > 0) chk({tag, "_hold"}, 32'(bad), 32'(s));
  endtask

  // From RESET entry: run the stages with lock delays db/da/dd.
  // Stop once stop_at has been reached.
  task automatic bringup_from_reset(int db, int da, int dd, logic [NB_RETRY-1:0] r,
                                    logic [2:0] stop_at);
    blk = '0; am = '0; dsk = 1'b0;
    hold(RESET_CYCLES - 1, S_RESET, "reset_len");
    step(); expect_st("wait_blk", S_BLK, r);
    if (stop_at == S_BLK) return;
    hold(db, S_BLK, "blk_wait");
    blk = '1;
    step(); expect_st("wait_am", S_AM, r);
    if (stop_at == S_AM) return;
    hold(da, S_AM, "am_wait");
    am = '1;
    step(); expect_st("wait_deskew", S_DESKEW, r);
    if (stop_at == S_DESKEW) return;
    hold(dd, S_DESKEW, "deskew_wait");
    dsk = 1'b1;
    step(); expect_st("enable_rx", S_ENRX, r); exp_ro++;
    step(); expect_st("link_up", S_UP, r);
  endtask

  task automatic start_run(string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    expect_st(tag, S_RESET, '0);
  endtask

  task automatic do_abort(string tag);
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_st(tag, S_IDLE, '0);
  endtask

  initial begin
    int L, M, d, lane;
    logic [2:0] nxt;
    rst = 1'b1; start = 1'b0; abort = 1'b0; limit = 24'd1000; maxr = '0;
    blk = '0; am = '0; dsk = 1'b0;
    step(); step();
    expect_st("after_reset", S_IDLE, '0);
    rst = 1'b0;
    mon_on = 1'b1;
    step();
    expect_st("idle_no_start", S_IDLE, '0);

    // Nominal bring-up: fixed delays first, then random ones below the limit.
    for (int k = 0; k < 3; k++) begin
      start_run("nom_start");
      if (k == 0) bringup_from_reset(50, 100, 20, '0, S_UP);
      else bringup_from_reset($urandom_range(0, 120), $urandom_range(0, 120),
                              $urandom_range(0, 120), '0, S_UP);
      hold(5, S_UP, "up_steady");
      do_abort("abort_up");
    end

    // Link loss: am_lock[7] drops for one cycle. Bring-up restarts with no retry charged.
    start_run("loss_start");
    bringup_from_reset(3, 4, 5, '0, S_UP);
    am[7] = 1'b0;
    step();
    am[7] = 1'b1;
    expect_st("link_loss", S_RESET, '0);
    bringup_from_reset($urandom_range(0, 30), $urandom_range(0, 30),
                       $urandom_range(0, 30), '0, S_UP);
    do_abort("abort_after_loss");

    // Partial block lock: the stage times out on every attempt until retries run out.
    for (int p = 0; p < 2; p++) begin
      L = (p == 0) ? 100 : int'($urandom_range(20, 90));
      M = (p == 0) ? 2 : int'($urandom_range(0, 3));
      limit = 24'(L);
      maxr  = 4'(M);
      lane  = int'($urandom_range(0, N_LANES - 1));
      start_run("part_start");
      blk = '0; am = '0; dsk = 1'b0;
      hold(RESET_CYCLES - 1, S_RESET, "part_reset_len");
      step(); expect_st("part_blk", S_BLK, '0);
      for (int a = 0; a <= M; a++) begin
        blk = ~(20'(1) << lane);
        start = (a == 0);
        hold(L - 1, S_BLK, "part_blk_wait");
        start = 1'b0;
        step();
        if (a < M) begin
          expect_st("part_retry", S_RESET, 4'(a + 1));
          hold(RESET_CYCLES - 1, S_RESET, "part_retry_reset");
          step(); expect_st("part_blk_again", S_BLK, 4'(a + 1));
        end else begin
          expect_st("part_fail", S_FAIL, 4'(M));
        end
      end
      hold(5, S_FAIL, "fail_steady");
      expect_st("fail_hold", S_FAIL, 4'(M));
      start_run("restart_from_fail");
      do_abort("abort_in_reset");
    end

    // Abort in WAIT_AM, then run a full sequence.
    limit = 24'd1000; maxr = 4'd3;
    start_run("abort_am_start");
    bringup_from_reset(10, 0, 0, '0, S_AM);
    hold(7, S_AM, "am_pre_abort");
    do_abort("abort_in_am");
    start_run("rerun_start");
    bringup_from_reset($urandom_range(0, 60), $urandom_range(0, 60),
                       $urandom_range(0, 60), '0, S_UP);
    do_abort("abort_rerun");

    // Losing block lock in WAIT_AM is a retry at once.
    start_run("lowloss_start");
    bringup_from_reset(2, 0, 0, '0, S_AM);
    hold($urandom_range(0, 20), S_AM, "am_pre_loss");
    blk[3] = 1'b0;
    step();
    expect_st("blk_loss_in_am", S_RESET, 4'd1);
    bringup_from_reset(5, 6, 7, 4'd1, S_UP);
    do_abort("abort_lowloss");

    // Deskew arrives exactly on the timeout cycle, then a real timeout.
    L = int'($urandom_range(10, 40));
    limit = 24'(L); maxr = 4'd3;
    start_run("edge_start");
    bringup_from_reset($urandom_range(0, L - 1), $urandom_range(0, L - 1), 0, '0, S_DESKEW);
    d = L - 1;
    hold(d, S_DESKEW, "deskew_edge_wait");
    dsk = 1'b1;
    step();
    nxt = stage_advances(d, L) ? S_ENRX : S_RESET;
    expect_st("deskew_on_timeout", nxt, '0);
    exp_ro++;
    step(); expect_st("edge_link_up", S_UP, '0);
    dsk = 1'b0;
    step(); expect_st("deskew_drop", S_RESET, '0);
    bringup_from_reset(1, 1, 0, '0, S_DESKEW);
    d = L;
    hold(L - 1, S_DESKEW, "deskew_to_wait");
    step();
    nxt = stage_advances(d, L) ? S_ENRX : S_RESET;
    expect_st("deskew_timeout", nxt, 4'd1);

    // Synchronous reset for one cycle in WAIT_DESKEW while retry is 1.
    bringup_from_reset(2, 2, 0, 4'd1, S_DESKEW);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_st("reset_in_deskew", S_IDLE, '0);

    // A limit of 0 never times out, even after a long wait.
    limit = '0; maxr = '0;
    start_run("nolimit_start");
    bringup_from_reset(0, 0, 0, '0, S_BLK);
    blk = ~(20'(1) << 11);
    hold(10000, S_BLK, "nolimit_wait");
    expect_st("nolimit_still_blk", S_BLK, '0);
    do_abort("abort_nolimit");

    // Compare the recorded trace and pulse count with the predictions.
    step();
    chk("reset_order_pulses", 32'(n_ro), 32'(exp_ro));
    chk("trace_len", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk("trace", 32'(obs_q[i]), 32'(exp_q[i]));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
